// File: rtl/cpu_bus_pkg.sv
// +---------------------------------------------------------------------------+
// | cpu_bus_pkg -- shared CPU bus source indices and bus dimensions.           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

package cpu_bus_pkg;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHIGH  = 18;
  localparam int SRC_ZLOW   = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

  localparam int N_BUS_SRC  = 24;
  localparam int BUS_WIDTH  = 32;

endpackage

`default_nettype wire

// File: rtl/bus_mux_reg_prio_enc.sv
// +---------------------------------------------------------------------------+
// | bus_prio_enc -- highest-index-wins priority encoder with multi-hot flag.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module bus_prio_enc #(
  parameter int N_SRC = 24,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] en,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic             multi
);

  // Ascending scan: the last set bit seen is the highest and wins.
  always_comb begin
    any   = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (en[i]) begin
        multi = multi | any;
        any   = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_mux_reg.sv
// +---------------------------------------------------------------------------+
// | bus_mux_reg -- registered priority bus mux with conflict detection.        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module bus_mux_reg
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int N_SRC = N_BUS_SRC,
  parameter int CNT_W = 8,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       src_out,
  input  logic                   conflict_clr,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [SEL_W-1:0]       bus_sel,
  output logic                   conflict,
  output logic                   conflict_sticky,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             any;
  logic             multi;
  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_word;

  bus_prio_enc #(
    .N_SRC (N_SRC),
    .IDX_W (SEL_W)
  ) u_prio_enc (
    .en    (src_out),
    .any   (any),
    .idx   (win_idx),
    .multi (multi)
  );

  always_comb begin
    win_word = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (win_idx == SEL_W'(i)) begin
        win_word = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      bus_out         <= '0;
      bus_valid       <= 1'b0;
      bus_sel         <= '0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      conflict_cnt    <= '0;
    end else begin
      bus_valid <= any;
      conflict  <= multi;
      if (any) begin
        bus_out <= win_word;
        bus_sel <= win_idx;
      end
      // A conflict coinciding with a clear request is kept as the first new count.
      if (conflict_clr) begin
        conflict_sticky <= multi;
        conflict_cnt    <= multi ? CNT_W'(1) : '0;
      end else if (multi) begin
        conflict_sticky <= 1'b1;
        if (conflict_cnt != CNT_MAX) begin
          conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_mux_reg.sv
// Testbench for bus_mux_reg: directed scenarios followed by random traffic,
// with a queue-based scoreboard fed by the driver and drained by a monitor.
`default_nettype none

module tb_bus_mux_reg;

  localparam int W  = 32;
  localparam int N  = 24;
  localparam int CW = 2;
  localparam int SW = 5;
  localparam int CMAX = 3;

  logic           clock;
  logic           clear;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_out;
  logic           conflict_clr;
  logic [W-1:0]   bus_out;
  logic           bus_valid;
  logic [SW-1:0]  bus_sel;
  logic           conflict;
  logic           conflict_sticky;
  logic [CW-1:0]  conflict_cnt;

  bus_mux_reg #(
    .WIDTH (W),
    .N_SRC (N),
    .CNT_W (CW)
  ) dut (
    .clock           (clock),
    .clear           (clear),
    .src_data        (src_data),
    .src_out         (src_out),
    .conflict_clr    (conflict_clr),
    .bus_out         (bus_out),
    .bus_valid       (bus_valid),
    .bus_sel         (bus_sel),
    .conflict        (conflict),
    .conflict_sticky (conflict_sticky),
    .conflict_cnt    (conflict_cnt)
  );

  typedef struct {
    logic [W-1:0]  bus;
    logic [SW-1:0] sel;
    logic          valid;
    logic          conf;
    logic          sticky;
    int            cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int n_vec = 0;
  int n_err = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: apply one input cycle to the architectural state.
  task automatic step(input logic [N-1:0] en, input logic clr, input logic cclr);
    int n;
    int top;
    src_out      = en;
    clear        = clr;
    conflict_clr = cclr;
    n   = $countones(en);
    top = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (en[i] && top < 0) top = i;
    end
    if (clr) begin
      m.bus = '0; m.sel = '0; m.valid = 1'b0;
      m.conf = 1'b0; m.sticky = 1'b0; m.cnt = 0;
    end else begin
      m.valid = (n > 0);
      if (n > 0) begin
        m.bus = src_data[top*W +: W];
        m.sel = SW'(top);
      end
      m.conf = (n >= 2);
      if (cclr) begin
        m.cnt    = m.conf ? 1 : 0;
        m.sticky = m.conf;
      end else if (m.conf) begin
        m.cnt    = (m.cnt + 1 > CMAX) ? CMAX : m.cnt + 1;
        m.sticky = 1'b1;
      end
    end
    q.push_back(m);
    @(posedge clock);
    #2;
  endtask

  task automatic set_word(input int idx, input logic [W-1:0] val);
    src_data[idx*W +: W] = val;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  exp_t e;
  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      chk("bus_out",         bus_out,                   e.bus);
      chk("bus_sel",         32'(bus_sel),              32'(e.sel));
      chk("bus_valid",       32'(bus_valid),            32'(e.valid));
      chk("conflict",        32'(conflict),             32'(e.conf));
      chk("conflict_sticky", 32'(conflict_sticky),      32'(e.sticky));
      chk("conflict_cnt",    32'(conflict_cnt),         32'(e.cnt));
    end
  end

  initial begin
    logic [N-1:0] en;
    int a;
    int b;
    clear        = 1'b1;
    conflict_clr = 1'b0;
    src_out      = '0;
    src_data     = '0;
    m.bus = '0; m.sel = '0; m.valid = 1'b0;
    m.conf = 1'b0; m.sticky = 1'b0; m.cnt = 0;

    // Reset with every enable asserted
    for (int i = 0; i < N; i++) set_word(i, W'($urandom()));
    step('1, 1'b1, 1'b0);
    step('1, 1'b1, 1'b0);

    // Single driver, then hold
    set_word(4, 32'hDEADBEEF);
    step(N'(1) << 4, 1'b0, 1'b0);
    set_word(4, 32'h1);
    repeat (3) step('0, 1'b0, 1'b0);

    // Priority and conflict
    set_word(2, 32'h11);
    set_word(21, 32'h22);
    step((N'(1) << 2) | (N'(1) << 21), 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);

    // Saturation: 5 back-to-back conflicts after clearing the counter
    step('0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      set_word(7, W'($urandom()));
      step((N'(1) << 3) | (N'(1) << 7), 1'b0, 1'b0);
    end

    // Clear race, then clear alone
    step((N'(1) << 0) | (N'(1) << 23), 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);

    // Clear overrides a conflict
    step('1, 1'b1, 1'b0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) set_word(i, W'($urandom()));
      case ($urandom_range(0, 3))
        0: en = '0;
        1: en = N'(1) << $urandom_range(0, N - 1);
        2: begin
          a  = $urandom_range(0, N - 1);
          b  = $urandom_range(0, N - 1);
          en = (N'(1) << a) | (N'(1) << b);
        end
        default: en = N'($urandom());
      endcase
      step(en, ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0));
    end
    step('0, 1'b0, 1'b0);

    #5;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
